crop_stream_cfg: RTL and testbench

Streaming raster-scan cropper. Extracts an OUT_ROWS x OUT_COLS window from each IN_ROWS x IN_COLS frame, with multi-channel pixels. The window origin is configured at runtime, once per frame. Cropped pixels are buffered in an internal FIFO and emitted on a valid/ready stream with an end-of-crop marker. Successor to the fixed-origin crop+FIFO block; it sits between the pixel source and the downstream model input.

---
 rtl/crop_pkg.sv | 20 ++
 rtl/crop_stream_cfg_if.sv | 37 +++
 rtl/stream_fifo.sv | 55 +++++
 rtl/crop_stream_cfg.sv | 126 ++++++++++++
 tb/tb_crop_stream_cfg.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/crop_pkg.sv
// Shared types and width helpers for the streaming cropper.
// Imported by the top level and the output FIFO.
package crop_pkg;

  typedef enum logic [0:0] {
    IDLE,
    STREAM
  } state_e;

  // Bits needed to index n positions (at least 1).
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // FIFO pointer width; the occupancy count uses one extra bit.
  function automatic int ptr_w(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/crop_stream_cfg_if.sv
// Config, input and output stream bundle of the cropper.
// master = pixel source / sink side, slave = cropper.
interface crop_stream_cfg_if #(
  parameter int PW = 12,
  parameter int YW = 6,
  parameter int XW = 6
);
  logic [YW-1:0] cfg_y;
  logic [XW-1:0] cfg_x;
  logic          cfg_valid;
  logic          cfg_ready;
  logic          cfg_err;
  logic [PW-1:0] pixel_in;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] pixel_out;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          frame_done;

  modport master (
    output cfg_y, cfg_x, cfg_valid,
    output pixel_in, in_valid, out_ready,
    input  cfg_ready, cfg_err, in_ready,
    input  pixel_out, out_valid, out_last,
    input  frame_done
  );

  modport slave (
    input  cfg_y, cfg_x, cfg_valid,
    input  pixel_in, in_valid, out_ready,
    output cfg_ready, cfg_err, in_ready,
    output pixel_out, out_valid, out_last,
    output frame_done
  );
endinterface

// File: rtl/stream_fifo.sv
// First-word-fall-through FIFO with registered storage.
// Head word reads as zero while empty.
module stream_fifo
  import crop_pkg::*;
#(
  parameter int WIDTH = 13,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = ptr_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign rdata_o = empty_o ? '0 : mem_q[rd_q];

  // Occupancy: simultaneous push and pop leaves it unchanged.
  always_comb begin
    cnt_d = cnt_q;
    if (push_ok && !pop_ok) cnt_d = cnt_q + 1'b1;
    if (pop_ok && !push_ok) cnt_d = cnt_q - 1'b1;
  end

  // Storage write; contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= wdata_i;
  end

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop_ok)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/crop_stream_cfg.sv
// Runtime-origin raster cropper feeding a FWFT output FIFO.
// Origin is accepted once per frame while idle.
module crop_stream_cfg
  import crop_pkg::*;
#(
  parameter int PIXEL_BIT_WIDTH = 12,
  parameter int CHANNELS        = 1,
  parameter int IN_ROWS         = 40,
  parameter int IN_COLS         = 40,
  parameter int OUT_ROWS        = 20,
  parameter int OUT_COLS        = 20,
  parameter int FIFO_DEPTH      = 16
) (
  input logic               clk,
  input logic               reset,
  crop_stream_cfg_if.slave  bus
);
  localparam int PW = PIXEL_BIT_WIDTH * CHANNELS;
  localparam int YW = cnt_w(IN_ROWS);
  localparam int XW = cnt_w(IN_COLS);
  localparam logic [YW-1:0] ROW_MAX = YW'(IN_ROWS - 1);
  localparam logic [XW-1:0] COL_MAX = XW'(IN_COLS - 1);

  state_e        state_q;
  logic [YW-1:0] row_q, y_q;
  logic [XW-1:0] col_q, x_q;
  logic          cfg_ready_q, cfg_err_q, done_q;

  logic [YW:0]   row_e, y_lo, y_hi;
  logic [XW:0]   col_e, x_lo, x_hi;
  logic          in_win, win_last, cfg_ok;
  logic          in_ready_w, in_hs, frame_end;
  logic          fifo_full, fifo_empty;
  logic [PW:0]   fifo_rd;

  assign row_e = {1'b0, row_q};
  assign col_e = {1'b0, col_q};
  assign y_lo  = {1'b0, y_q};
  assign x_lo  = {1'b0, x_q};
  assign y_hi  = y_lo + (YW+1)'(OUT_ROWS - 1);
  assign x_hi  = x_lo + (XW+1)'(OUT_COLS - 1);

  assign in_win = (row_e >= y_lo) && (row_e <= y_hi) &&
                  (col_e >= x_lo) && (col_e <= x_hi);
  assign win_last = (row_e == y_hi) && (col_e == x_hi);

  assign cfg_ok =
    (({1'b0, bus.cfg_y} + (YW+1)'(OUT_ROWS)) <= (YW+1)'(IN_ROWS)) &&
    (({1'b0, bus.cfg_x} + (XW+1)'(OUT_COLS)) <= (XW+1)'(IN_COLS));

  // Out-of-window pixels never stall; only window pixels see full.
  assign in_ready_w = (state_q == STREAM) & (~in_win | ~fifo_full);
  assign in_hs      = bus.in_valid & in_ready_w;
  assign frame_end  = (row_q == ROW_MAX) && (col_q == COL_MAX);

  assign bus.in_ready   = in_ready_w;
  assign bus.cfg_ready  = cfg_ready_q;
  assign bus.cfg_err    = cfg_err_q;
  assign bus.frame_done = done_q;
  assign bus.out_valid  = ~fifo_empty;
  assign bus.pixel_out  = fifo_rd[PW-1:0];
  assign bus.out_last   = fifo_rd[PW];

  // Frame FSM: config check, raster counters, status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      row_q       <= '0;
      col_q       <= '0;
      y_q         <= '0;
      x_q         <= '0;
      cfg_ready_q <= 1'b0;
      cfg_err_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      cfg_err_q <= 1'b0;
      done_q    <= 1'b0;
      unique case (state_q)
        IDLE: begin
          cfg_ready_q <= 1'b1;
          if (bus.cfg_valid && cfg_ready_q) begin
            if (cfg_ok) begin
              y_q         <= bus.cfg_y;
              x_q         <= bus.cfg_x;
              state_q     <= STREAM;
              cfg_ready_q <= 1'b0;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        STREAM: begin
          if (in_hs) begin
            if (frame_end) begin
              row_q       <= '0;
              col_q       <= '0;
              state_q     <= IDLE;
              done_q      <= 1'b1;
              cfg_ready_q <= 1'b1;
            end else if (col_q == COL_MAX) begin
              col_q <= '0;
              row_q <= row_q + 1'b1;
            end else begin
              col_q <= col_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  stream_fifo #(
    .WIDTH (PW + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (in_hs & in_win),
    .wdata_i ({win_last, bus.pixel_in}),
    .pop_i   (bus.out_ready),
    .rdata_o (fifo_rd),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );
endmodule

// File: tb/tb_crop_stream_cfg.sv
// Scoreboard bench for crop_stream_cfg, 3-channel pixels.
// Expected crop words are queued at cfg accept, popped by monitor.
module tb_crop_stream_cfg;
  localparam int PBW = 12;
  localparam int CH  = 3;
  localparam int IR  = 40;
  localparam int IC  = 40;
  localparam int OR  = 20;
  localparam int OC  = 20;
  localparam int FD  = 16;
  localparam int PW  = PBW * CH;

  typedef struct packed {
    logic          last;
    logic [PW-1:0] pix;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  crop_stream_cfg_if #(.PW(PW), .YW(6), .XW(6)) bus();

  crop_stream_cfg #(
    .PIXEL_BIT_WIDTH (PBW),
    .CHANNELS        (CH),
    .IN_ROWS         (IR),
    .IN_COLS         (IC),
    .OUT_ROWS        (OR),
    .OUT_COLS        (OC),
    .FIFO_DEPTH      (FD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t exp_q[$];
  int   outlog[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_last = 0;
  int   n_acc = 0;
  bit   rand_out = 1'b0;

  function automatic logic [PW-1:0] pix(input int i);
    logic [11:0] a;
    a = 12'(i);
    return {a + 12'd7, a ^ 12'hA5A, a};
  endfunction

  task automatic chk(input string nm, input longint act, input longint expv);
    n_chk++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  // Monitor: a handshake completes at the next rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("out_unexpected", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        chk("out_pixel", bus.pixel_out, e.pix);
        chk("out_last", bus.out_last, e.last);
      end
      outlog.push_back(int'(bus.pixel_out[11:0]));
      if (bus.out_last) n_last++;
    end
  end

  always @(posedge clk) begin
    if (rand_out) begin
      #1 bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic send_cfg(input int y, input int x, input bit ok);
    int w;
    @(posedge clk); #1;
    bus.cfg_y = 6'(y);
    bus.cfg_x = 6'(x);
    bus.cfg_valid = 1'b1;
    w = 0;
    @(negedge clk);
    while (!bus.cfg_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("cfg_ready_wait", bus.cfg_ready, 1);
    @(posedge clk); #1;
    bus.cfg_valid = 1'b0;
    @(negedge clk);
    chk("cfg_err", bus.cfg_err, ok ? 0 : 1);
    chk("cfg_ready_after", bus.cfg_ready, ok ? 0 : 1);
    if (!ok) chk("in_ready_rejected", bus.in_ready, 0);
    if (ok) begin
      for (int r = y; r < y + OR; r++)
        for (int c = x; c < x + OC; c++)
          exp_q.push_back({1'(r == y+OR-1 && c == x+OC-1), pix(r*IC + c)});
    end
  endtask

  task automatic frame(input bit rin, input int stop_at, input int drop_at);
    int w;
    @(posedge clk); #1;
    for (int i = 0; i < IR*IC; i++) begin
      if (i == stop_at) return;
      if (i == drop_at) bus.out_ready = 1'b0;
      if (rin) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
      end
      bus.pixel_in = pix(i);
      bus.in_valid = 1'b1;
      w = 0;
      @(negedge clk);
      while (!bus.in_ready && w < 300) begin
        @(negedge clk);
        w++;
      end
      if (!bus.in_ready) begin
        chk("in_ready_timeout", w, 0);
        bus.in_valid = 1'b0;
        return;
      end
      n_acc++;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
    end
    @(negedge clk);
    chk("frame_done", bus.frame_done, 1);
    chk("idle_cfg_ready", bus.cfg_ready, 1);
    chk("idle_in_ready", bus.in_ready, 0);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 5000) begin
      @(negedge clk);
      w++;
    end
    chk("drain", exp_q.size(), 0);
    @(negedge clk);
    chk("fifo_empty", bus.out_valid, 0);
  endtask

  initial begin
    int base, lb;
    bus.cfg_y = '0;
    bus.cfg_x = '0;
    bus.cfg_valid = 1'b0;
    bus.pixel_in = '0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cfg_ready", bus.cfg_ready, 0);
    chk("rst_cfg_err", bus.cfg_err, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_frame_done", bus.frame_done, 0);
    chk("rst_pixel_out", bus.pixel_out, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Origin (10,10), free-running sink.
    base = outlog.size(); lb = n_last;
    send_cfg(10, 10, 1);
    frame(0, -1, -1);
    drain();
    chk("t1_count", outlog.size() - base, 400);
    chk("t1_first", outlog[base], 410);
    chk("t1_last", outlog[outlog.size()-1], 1189);
    chk("t1_nlast", n_last - lb, 1);

    // Out-of-range origin rejected, then bottom-right corner.
    send_cfg(25, 10, 0);
    base = outlog.size();
    send_cfg(20, 20, 1);
    frame(0, -1, -1);
    drain();
    chk("t2_first", outlog[base], 820);
    chk("t2_last", outlog[outlog.size()-1], 1599);

    // Stalled sink: only FIFO_DEPTH window pixels get in.
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    base = outlog.size();
    n_acc = 0;
    send_cfg(0, 0, 1);
    fork
      frame(0, -1, -1);
      begin
        int w;
        w = 0;
        while (n_acc < 16 && w < 200) begin
          @(negedge clk);
          w++;
        end
        repeat (20) @(negedge clk);
        chk("bp_accepted", n_acc, 16);
        chk("bp_in_ready", bus.in_ready, 0);
        chk("bp_out_valid", bus.out_valid, 1);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_count", outlog.size() - base, 400);
    chk("bp_row1_first", outlog[base + 20], 40);

    // Random valid/ready, two frames back to back.
    lb = n_last;
    base = outlog.size();
    rand_out = 1'b1;
    send_cfg(10, 10, 1);
    frame(1, -1, -1);
    send_cfg(0, 20, 1);
    frame(1, -1, -1);
    drain();
    rand_out = 1'b0;
    @(posedge clk); #2;
    bus.out_ready = 1'b1;
    chk("rnd_count", outlog.size() - base, 800);
    chk("rnd_nlast", n_last - lb, 2);
    chk("rnd_f2_first", outlog[base + 400], 20);

    // Reset mid-frame with words still buffered.
    send_cfg(10, 10, 1);
    frame(0, 700, 690);
    @(negedge clk);
    chk("mid_fifo_busy", bus.out_valid, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_out_valid", bus.out_valid, 0);
    chk("mid_pixel_out", bus.pixel_out, 0);
    chk("mid_out_last", bus.out_last, 0);
    chk("mid_in_ready", bus.in_ready, 0);
    chk("mid_cfg_ready", bus.cfg_ready, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    bus.out_ready = 1'b1;
    base = outlog.size();
    send_cfg(5, 5, 1);
    frame(0, -1, -1);
    drain();
    chk("post_rst_first", outlog[base], 205);
    chk("post_rst_count", outlog.size() - base, 400);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
